// File: rtl/pkt_fifo_pkg.sv
// Shared default sizing for the packet FIFO slice.
// Geometry itself stays a module parameter so each instance can size itself.
package pkt_fifo_pkg;
    localparam int PKT_FIFO_AW_DEFAULT = 8;
    localparam int PKT_FIFO_DW_DEFAULT = 8;
endpackage

// File: rtl/pkt_fifo_ram.sv
// Simple dual-port RAM with registered read; shaped to map onto an SB_RAM40_4K.
// Read data holds when re is low, which the top uses as its prefetch stage.
module pkt_fifo_ram
    import pkt_fifo_pkg::*;
#(
    parameter int AW    = PKT_FIFO_AW_DEFAULT,
    parameter int WIDTH = PKT_FIFO_DW_DEFAULT + 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pkt_fifo.sv
// Packet FIFO: bytes become visible to the reader only once their packet's last
// byte is stored; packets that overflow storage are rolled back and flagged on ovf.
module pkt_fifo
    import pkt_fifo_pkg::*;
#(
    parameter int AW = PKT_FIFO_AW_DEFAULT,
    parameter int DW = PKT_FIFO_DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_last,
    input  logic          wr_ena,
    output logic          wr_full,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic          rd_valid,
    input  logic          rd_ena,
    output logic [AW:0]   pkt_count,
    output logic          ovf
);

    localparam int EW = DW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] cmt_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr_inc;
    logic          bad;
    logic          s1_valid;
    logic          accept;
    logic          commit;
    logic          pop_last;
    logic          out_take;
    logic          s1_free;
    logic          issue;
    logic [EW-1:0] ram_rdata;

    // rd_ptr is the fetch pointer: entries already in the read pipeline are
    // free for reuse, and writes can never reach a committed unread address.
    assign wr_ptr_inc = wr_ptr + AW'(1);
    assign wr_full    = (wr_ptr_inc == rd_ptr);
    assign accept     = wr_ena && !wr_full && !bad;
    assign commit     = accept && wr_last;
    assign pop_last   = rd_valid && rd_ena && rd_last;
    assign out_take   = !rd_valid || rd_ena;
    assign s1_free    = !s1_valid || out_take;
    assign issue      = (rd_ptr != cmt_ptr) && s1_free;

    pkt_fifo_ram #(
        .AW    (AW),
        .WIDTH (EW)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata ({wr_last, wr_data}),
        .re    (issue),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // Writer: a byte that cannot be stored poisons the packet; its last byte
    // rewinds to the previous commit point and raises the one-cycle ovf pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            cmt_ptr <= '0;
            bad     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            ovf <= 1'b0;
            if (wr_ena) begin
                if (wr_full || bad) begin
                    if (wr_last) begin
                        wr_ptr <= cmt_ptr;
                        bad    <= 1'b0;
                        ovf    <= 1'b1;
                    end else begin
                        bad <= 1'b1;
                    end
                end else begin
                    wr_ptr <= wr_ptr_inc;
                    if (wr_last) begin
                        cmt_ptr <= wr_ptr_inc;
                    end
                end
            end
        end
    end

    // Reader: RAM output register is stage 1, output register is stage 2;
    // both advance together so a held rd_ena drains one byte per clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            s1_valid <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
        end else begin
            if (issue) begin
                rd_ptr   <= rd_ptr + AW'(1);
                s1_valid <= 1'b1;
            end else if (out_take) begin
                s1_valid <= 1'b0;
            end
            if (out_take) begin
                rd_valid <= s1_valid;
                if (s1_valid) begin
                    rd_last <= ram_rdata[DW];
                    rd_data <= ram_rdata[DW-1:0];
                end else begin
                    rd_last <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count <= '0;
        end else begin
            case ({commit, pop_last})
                2'b10:   pkt_count <= pkt_count + (AW+1)'(1);
                2'b01:   pkt_count <= pkt_count - (AW+1)'(1);
                default: pkt_count <= pkt_count;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_fifo.sv
// Directed bench for pkt_fifo at AW=4: commit latency, partial packets, overflow
// rollback, simultaneous commit/pop, back-to-back reads and mid-packet reset.
module tb_pkt_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wr_data = '0;
    logic       wr_last = 1'b0;
    logic       wr_ena = 1'b0;
    logic       wr_full;
    logic [7:0] rd_data;
    logic       rd_last;
    logic       rd_valid;
    logic       rd_ena = 1'b0;
    logic [4:0] pkt_count;
    logic       ovf;

    int checks = 0;
    int errors = 0;
    logic seen_valid;
    logic seen_ovf;

    pkt_fifo #(.AW(4), .DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_data   (wr_data),
        .wr_last   (wr_last),
        .wr_ena    (wr_ena),
        .wr_full   (wr_full),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .rd_valid  (rd_valid),
        .rd_ena    (rd_ena),
        .pkt_count (pkt_count),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic wl, input logic [7:0] wd, input logic re);
        wr_ena  = we;
        wr_last = wl;
        wr_data = wd;
        rd_ena  = re;
        @(posedge clk);
        #1;
    endtask

    task automatic checkHead(input string tag, input logic [7:0] data, input logic last);
        checkOutput({tag, "_valid"}, 32'(rd_valid), 32'd1);
        checkOutput({tag, "_data"}, 32'(rd_data), 32'(data));
        checkOutput({tag, "_last"}, 32'(rd_last), 32'(last));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_valid"}, 32'(rd_valid), 32'd0);
        checkOutput({tag, "_last"}, 32'(rd_last), 32'd0);
        checkOutput({tag, "_data"}, 32'(rd_data), 32'd0);
        checkOutput({tag, "_full"}, 32'(wr_full), 32'd0);
        checkOutput({tag, "_count"}, 32'(pkt_count), 32'd0);
        checkOutput({tag, "_ovf"}, 32'(ovf), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 8'h00, 0);
        applyStimulus(0, 0, 8'h00, 0);
        checkResetState("reset");
        rst = 1'b0;

        // Three-byte packet: visible two clocks after the commit edge.
        applyStimulus(1, 0, 8'hA4, 0);
        applyStimulus(1, 0, 8'h01, 0);
        applyStimulus(1, 1, 8'h02, 0);
        checkOutput("t1_count_commit", 32'(pkt_count), 32'd1);
        checkOutput("t1_valid_c0", 32'(rd_valid), 32'd0);
        applyStimulus(0, 0, 8'h00, 0);
        checkOutput("t1_valid_c1", 32'(rd_valid), 32'd0);
        applyStimulus(0, 0, 8'h00, 0);
        checkHead("t1_b0", 8'hA4, 1'b0);
        applyStimulus(0, 0, 8'h00, 1);
        checkHead("t1_b1", 8'h01, 1'b0);
        applyStimulus(0, 0, 8'h00, 1);
        checkHead("t1_b2", 8'h02, 1'b1);
        checkOutput("t1_count_before_pop", 32'(pkt_count), 32'd1);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("t1_valid_drained", 32'(rd_valid), 32'd0);
        checkOutput("t1_count_drained", 32'(pkt_count), 32'd0);

        // Unterminated packet must never reach the reader.
        applyStimulus(1, 0, 8'h5A, 0);
        applyStimulus(1, 0, 8'h5B, 0);
        seen_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(0, 0, 8'h00, 1);
            seen_valid = seen_valid | rd_valid;
        end
        checkOutput("t2_no_valid", 32'(seen_valid), 32'd0);
        checkOutput("t2_count", 32'(pkt_count), 32'd0);
        rst = 1'b1;
        applyStimulus(0, 0, 8'h00, 0);
        rst = 1'b0;

        // Reset mid-packet with a committed packet pending and strobes active.
        applyStimulus(1, 1, 8'h55, 0);
        applyStimulus(1, 0, 8'h61, 0);
        applyStimulus(1, 0, 8'h62, 0);
        applyStimulus(1, 0, 8'h63, 0);
        checkOutput("t6_pre_valid", 32'(rd_valid), 32'd1);
        checkOutput("t6_pre_count", 32'(pkt_count), 32'd1);
        rst = 1'b1;
        applyStimulus(1, 1, 8'h64, 1);
        checkResetState("t6_rst");
        rst = 1'b0;
        applyStimulus(1, 0, 8'h21, 0);
        applyStimulus(1, 1, 8'h22, 0);
        applyStimulus(0, 0, 8'h00, 0);
        applyStimulus(0, 0, 8'h00, 0);
        checkHead("t6_b0", 8'h21, 1'b0);
        applyStimulus(0, 0, 8'h00, 1);
        checkHead("t6_b1", 8'h22, 1'b1);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("t6_valid_drained", 32'(rd_valid), 32'd0);
        checkOutput("t6_count_drained", 32'(pkt_count), 32'd0);

        // Oversized packet: 15 bytes fill storage, the rest are dropped.
        seen_valid = 1'b0;
        seen_ovf   = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1, (k == 20), 8'(8'h80 + k), 0);
            seen_valid = seen_valid | rd_valid;
            if (k < 20) seen_ovf = seen_ovf | ovf;
            if (k == 14) checkOutput("t3_full_b14", 32'(wr_full), 32'd0);
            if (k == 15) checkOutput("t3_full_b15", 32'(wr_full), 32'd1);
            if (k == 19) checkOutput("t3_full_b19", 32'(wr_full), 32'd1);
        end
        checkOutput("t3_ovf_pulse", 32'(ovf), 32'd1);
        checkOutput("t3_full_after_drop", 32'(wr_full), 32'd0);
        checkOutput("t3_no_early_ovf", 32'(seen_ovf), 32'd0);
        applyStimulus(0, 0, 8'h00, 0);
        checkOutput("t3_ovf_clear", 32'(ovf), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 8'h00, 0);
            seen_valid = seen_valid | rd_valid;
        end
        checkOutput("t3_no_valid", 32'(seen_valid), 32'd0);
        checkOutput("t3_count", 32'(pkt_count), 32'd0);
        applyStimulus(1, 0, 8'h10, 0);
        applyStimulus(1, 0, 8'h11, 0);
        applyStimulus(1, 1, 8'h12, 0);
        checkOutput("t3_count_commit", 32'(pkt_count), 32'd1);
        applyStimulus(0, 0, 8'h00, 0);
        applyStimulus(0, 0, 8'h00, 0);
        checkHead("t3_b0", 8'h10, 1'b0);
        applyStimulus(0, 0, 8'h00, 1);
        checkHead("t3_b1", 8'h11, 1'b0);
        applyStimulus(0, 0, 8'h00, 1);
        checkHead("t3_b2", 8'h12, 1'b1);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("t3_count_drained", 32'(pkt_count), 32'd0);

        // Commit and final-byte pop on the same edge leave the count unchanged.
        applyStimulus(1, 1, 8'h33, 0);
        applyStimulus(0, 0, 8'h00, 0);
        applyStimulus(0, 0, 8'h00, 0);
        checkHead("t4_first", 8'h33, 1'b1);
        checkOutput("t4_count_pre", 32'(pkt_count), 32'd1);
        applyStimulus(1, 1, 8'h44, 1);
        checkOutput("t4_count_same", 32'(pkt_count), 32'd1);
        applyStimulus(0, 0, 8'h00, 0);
        applyStimulus(0, 0, 8'h00, 0);
        checkHead("t4_second", 8'h44, 1'b1);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("t4_count_drained", 32'(pkt_count), 32'd0);

        // Eight single-byte packets drained back to back.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 1, 8'(8'hC0 + i), 0);
        end
        applyStimulus(0, 0, 8'h00, 0);
        checkOutput("t5_count", 32'(pkt_count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            checkHead($sformatf("t5_b%0d", i), 8'(8'hC0 + i), 1'b1);
            applyStimulus(0, 0, 8'h00, 1);
        end
        checkOutput("t5_valid_drained", 32'(rd_valid), 32'd0);
        checkOutput("t5_count_drained", 32'(pkt_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
